// File: rtl/osc_state_bank_pkg.sv
// Shared definitions for the oscillator state bank.
//   cfg_sel_e   : encodings of the cfg_sel config port
//   osc_state_t : per-channel stored state (periods, enable, counter, phase)
// OSC_PERIOD_BITS fixes the field width of osc_state_t; the bank's
// PERIOD_BITS parameter must be left equal to it.
package osc_state_bank_pkg;

  localparam int OSC_PERIOD_BITS = 8;

  typedef enum logic [1:0] {
    CFG_PERIOD0  = 2'd0,
    CFG_PERIOD1  = 2'd1,
    CFG_ENABLE   = 2'd2,
    CFG_RESERVED = 2'd3
  } cfg_sel_e;

  typedef struct packed {
    logic [OSC_PERIOD_BITS-1:0] period0;
    logic [OSC_PERIOD_BITS-1:0] period1;
    logic                       enable;
    logic [OSC_PERIOD_BITS-1:0] counter;
    logic                       phase;
  } osc_state_t;

endpackage

// File: rtl/osc_state_bank_if.sv
// Bus between the state bank and the stateless Osc_Counter update unit.
//   master (bank)        : drives cur_ch and the stored state of that channel,
//                          receives the update unit's results.
//   slave  (update unit) : receives the state, drives osc_counter_we,
//                          osc_next_counter and osc_trigger combinationally.
interface osc_state_bank_if
  import osc_state_bank_pkg::*;
#(
  parameter int CH_BITS     = 2,
  parameter int PERIOD_BITS = OSC_PERIOD_BITS
);

  logic [CH_BITS-1:0]     cur_ch;
  logic [PERIOD_BITS-1:0] osc_period0;
  logic [PERIOD_BITS-1:0] osc_period1;
  logic                   osc_enable;
  logic [PERIOD_BITS-1:0] osc_counter;
  logic                   osc_counter_we;
  logic [PERIOD_BITS-1:0] osc_next_counter;
  logic                   osc_trigger;

  modport master (
    output cur_ch, osc_period0, osc_period1, osc_enable, osc_counter,
    input  osc_counter_we, osc_next_counter, osc_trigger
  );

  modport slave (
    input  cur_ch, osc_period0, osc_period1, osc_enable, osc_counter,
    output osc_counter_we, osc_next_counter, osc_trigger
  );

endinterface

// File: rtl/osc_state_bank.sv
// Time-multiplexed state store and round-robin channel sequencer. One channel
// is visited per clock; its stored state is presented on the osc bus and the
// update unit's results are written back at the following edge.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   cfg_we/ch/sel/data : config writes (period0, period1, enable)
//   osc (master)     : cur_ch + stored state out, update results in
//   phase            : per-channel square-wave bits
//   trig_valid/trig_ch : registered one-cycle trigger report
//   frame_start      : high while cur_ch == 0
module osc_state_bank
  import osc_state_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PERIOD_BITS  = OSC_PERIOD_BITS,
  parameter int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [CH_BITS-1:0]      cfg_ch,
  input  logic [1:0]              cfg_sel,
  input  logic [PERIOD_BITS-1:0]  cfg_data,
  osc_state_bank_if.master        osc,
  output logic [NUM_CHANNELS-1:0] phase,
  output logic                    trig_valid,
  output logic [CH_BITS-1:0]      trig_ch,
  output logic                    frame_start
);

  osc_state_t         state_q [NUM_CHANNELS];
  osc_state_t         state_d [NUM_CHANNELS];
  osc_state_t         cur_state;
  logic [CH_BITS-1:0] cur_ch_q, cur_ch_d;
  logic               trig_valid_q, trig_valid_d;
  logic [CH_BITS-1:0] trig_ch_q, trig_ch_d;

  // Read side: state of the visited channel, straight from the registers, so
  // a config write landing this cycle is only seen on the next visit.
  always_comb begin
    cur_state = state_q[0];
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cur_ch_q == CH_BITS'(i)) begin
        cur_state = state_q[i];
      end
    end
  end

  assign osc.cur_ch      = cur_ch_q;
  assign osc.osc_period0 = cur_state.period0;
  assign osc.osc_period1 = cur_state.period1;
  assign osc.osc_enable  = cur_state.enable;
  assign osc.osc_counter = cur_state.counter;

  // Next state: writeback first, config second so an enable-0 clear overrides
  // a same-cycle counter/phase writeback. Out-of-range cfg_ch matches no index.
  always_comb begin
    state_d      = state_q;
    cur_ch_d     = (cur_ch_q == CH_BITS'(NUM_CHANNELS - 1)) ? '0 : cur_ch_q + 1'b1;
    trig_valid_d = osc.osc_trigger;
    trig_ch_d    = osc.osc_trigger ? cur_ch_q : trig_ch_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cur_ch_q == CH_BITS'(i)) begin
        if (osc.osc_counter_we) begin
          state_d[i].counter = osc.osc_next_counter;
        end
        if (osc.osc_trigger) begin
          state_d[i].phase = ~state_q[i].phase;
        end
      end
      if (cfg_we && (cfg_ch == CH_BITS'(i))) begin
        case (cfg_sel_e'(cfg_sel))
          CFG_PERIOD0: state_d[i].period0 = cfg_data;
          CFG_PERIOD1: state_d[i].period1 = cfg_data;
          CFG_ENABLE: begin
            state_d[i].enable = cfg_data[0];
            if (!cfg_data[0]) begin
              state_d[i].counter = '0;
              state_d[i].phase   = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage boundary: per-channel state, sequencer and trigger report.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= '0;
      end
      cur_ch_q     <= '0;
      trig_valid_q <= 1'b0;
      trig_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
      cur_ch_q     <= cur_ch_d;
      trig_valid_q <= trig_valid_d;
      trig_ch_q    <= trig_ch_d;
    end
  end

  always_comb begin
    phase = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      phase[i] = state_q[i].phase;
    end
  end

  assign trig_valid  = trig_valid_q;
  assign trig_ch     = trig_ch_q;
  assign frame_start = (cur_ch_q == '0);

endmodule

// File: tb/tb_osc_state_bank.sv
// Bench for osc_state_bank with 4 channels, 8-bit periods. A behavioural
// update unit (LOG2_STEP = 0, period0 = 0) closes the loop: an enabled
// channel whose counter is 0 triggers and reloads period1-1, otherwise it
// counts down. Expected trigger cycles are hand-computed and pushed into a
// scoreboard keyed by cycle; a monitor compares on every cycle.
module tb_osc_state_bank;
  import osc_state_bank_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_data = '0;
  logic [3:0] phase;
  logic       trig_valid;
  logic [1:0] trig_ch;
  logic       frame_start;

  osc_state_bank_if #(.CH_BITS(2), .PERIOD_BITS(8)) osc_if ();

  osc_state_bank #(.NUM_CHANNELS(4), .PERIOD_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .osc         (osc_if),
    .phase       (phase),
    .trig_valid  (trig_valid),
    .trig_ch     (trig_ch),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Behavioural update unit.
  always_comb begin
    osc_if.osc_counter_we   = osc_if.osc_enable;
    osc_if.osc_trigger      = osc_if.osc_enable && (osc_if.osc_counter == 8'd0);
    osc_if.osc_next_counter = osc_if.osc_trigger ? (osc_if.osc_period1 - 8'd1)
                                                 : (osc_if.osc_counter - 8'd1);
  end

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int exp_ch [int];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int ch);
    exp_ch[c] = ch;
  endtask

  // Monitor: sequencer and trigger scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int expv;
      expv = exp_ch.exists(cyc) ? 1 : 0;
      chk("cur_ch", int'(osc_if.cur_ch), cyc % 4);
      chk("frame_start", int'(frame_start), (cyc % 4 == 0) ? 1 : 0);
      chk("trig_valid", int'(trig_valid), expv);
      if (expv == 1) begin
        if (trig_valid) chk("trig_ch", int'(trig_ch), exp_ch[cyc]);
        exp_ch.delete(cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    int guard = 0;
    while (cyc != n && guard < 1000) begin
      step();
      guard++;
    end
    chk("wait_cycle", cyc, n);
  endtask

  task automatic cfg(input int ch, input logic [1:0] sel, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_sel  = sel;
    cfg_data = 8'(data);
    step();
    cfg_we   = 1'b0;
    cfg_sel  = 2'd0;
    cfg_data = 8'd0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state (cycle 0), then ch1 period0=0, period1=3, enable.
    chk("rst_phase", int'(phase), 0);
    chk("rst_trig_valid", int'(trig_valid), 0);
    chk("rst_trig_ch", int'(trig_ch), 0);
    chk("rst_enable_ch0", int'(osc_if.osc_enable), 0);
    chk("rst_counter_ch0", int'(osc_if.osc_counter), 0);
    cfg(1, CFG_PERIOD0, 0);
    chk("rst_enable_ch1", int'(osc_if.osc_enable), 0);
    chk("same_visit_period1", int'(osc_if.osc_period1), 0);
    cfg(1, CFG_PERIOD1, 3);
    chk("rst_enable_ch2", int'(osc_if.osc_enable), 0);
    push(6, 1); push(18, 1); push(30, 1); push(42, 1);
    cfg(1, CFG_ENABLE, 1);
    chk("rst_enable_ch3", int'(osc_if.osc_enable), 0);

    // ch0 P=2 and ch3 P=5, enabled back to back.
    cfg(0, CFG_PERIOD1, 2);
    cfg(3, CFG_PERIOD1, 5);
    chk("ch1_visit_period1", int'(osc_if.osc_period1), 3);
    chk("ch1_visit_enable", int'(osc_if.osc_enable), 1);
    chk("ch1_visit_counter", int'(osc_if.osc_counter), 0);
    for (int c = 9; c <= 97; c += 8) push(c, 0);
    cfg(0, CFG_ENABLE, 1);
    for (int c = 8; c <= 88; c += 20) push(c, 3);
    cfg(3, CFG_ENABLE, 1);

    // ch2 P=4, used for the clear/writeback collision.
    cfg(2, CFG_PERIOD1, 4);
    push(11, 2); push(27, 2); push(43, 2);
    cfg(2, CFG_ENABLE, 1);

    wait_until(12);
    chk("phase_c12", int'(phase), 4'b1111);
    wait_until(20);
    chk("phase_c20", int'(phase), 4'b1100);

    // ch1 period1 3 -> 6 mid-count: reload at the trigger in cycle 41 uses 6.
    wait_until(34);
    push(66, 1); push(90, 1);
    cfg(1, CFG_PERIOD1, 6);

    // Disable ch2 in the very cycle it is serviced and triggering.
    wait_until(42);
    cfg_we   = 1'b1;
    cfg_ch   = 2'd2;
    cfg_sel  = CFG_ENABLE;
    cfg_data = 8'd0;
    chk("collide_enable_presented", int'(osc_if.osc_enable), 1);
    chk("collide_counter_presented", int'(osc_if.osc_counter), 0);
    step();
    cfg_we  = 1'b0;
    cfg_sel = 2'd0;

    wait_until(44);
    chk("phase_c44", int'(phase), 4'b0001);
    wait_until(45);
    chk("ch1_new_period1", int'(osc_if.osc_period1), 6);
    chk("ch1_reload_counter", int'(osc_if.osc_counter), 5);
    wait_until(46);
    chk("ch2_cleared_counter", int'(osc_if.osc_counter), 0);
    chk("ch2_cleared_enable", int'(osc_if.osc_enable), 0);

    // Reserved cfg_sel must not touch ch1 (data 0 would disable it).
    wait_until(50);
    cfg(1, CFG_RESERVED, 0);

    // Mid-run reset during ch0's trigger cycle: the trigger is dropped.
    wait_until(104);
    reset = 1'b1;
    step();
    chk("mid_rst_trig_valid", int'(trig_valid), 0);
    chk("mid_rst_phase", int'(phase), 0);
    chk("mid_rst_cur_ch", int'(osc_if.cur_ch), 0);
    chk("mid_rst_trig_ch", int'(trig_ch), 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("mid_rst_enable", int'(osc_if.osc_enable), 0);
      chk("mid_rst_period1", int'(osc_if.osc_period1), 0);
      chk("mid_rst_counter", int'(osc_if.osc_counter), 0);
      step();
    end
    wait_until(30);
    chk("mid_rst_phase_idle", int'(phase), 0);
    chk("sb_leftover", exp_ch.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
